board_diff_fsm: RTL and testbench

// Consumes the 162-bit 9x9 Go board produced by the UART packet receiver.

---
 rtl/go_board_pkg.sv | 57 +++++
 rtl/board_diff_fsm_sq_mux.sv | 18 +
 rtl/board_diff_fsm.sv | 162 ++++++++++++++++
 tb/tb_board_diff_fsm.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/go_board_pkg.sv
// Shared definitions for the 9x9 Go board diff block: geometry, stone
// encoding, one-hot FSM states and small combinational helpers.
package go_board_pkg;

    localparam int BOARD_N  = 9;
    localparam int SQ_BITS  = 2;
    localparam int NUM_SQ   = BOARD_N * BOARD_N;
    localparam int BOARD_W  = NUM_SQ * SQ_BITS;
    localparam int IDX_W    = 7;
    localparam logic [IDX_W-1:0] LAST_IDX = 7'(NUM_SQ - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        BLACK   = 2'b01,
        WHITE   = 2'b10,
        ILLEGAL = 2'b11
    } stone_t;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_CHECK = 5'b00010,
        S_SCAN  = 5'b00100,
        S_EMIT  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    typedef struct packed {
        logic [3:0] row;
        logic [3:0] col;
    } rowcol_t;

    // Square index to (row, col) through a fixed comparator chain against
    // multiples of BOARD_N, so no runtime divider is built.
    function automatic rowcol_t sq_rowcol(input logic [IDX_W-1:0] idx);
        rowcol_t rc;
        rc.row = '0;
        rc.col = '0;
        for (int r = 0; r < BOARD_N; r++) begin
            if (idx >= 7'(r * BOARD_N)) begin
                rc.row = 4'(r);
                rc.col = 4'(idx - 7'(r * BOARD_N));
            end
        end
        return rc;
    endfunction

    // True when any square of the board carries the illegal code 11.
    function automatic logic has_illegal(input logic [BOARD_W-1:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (b[2*i+1] && b[2*i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/board_diff_fsm_sq_mux.sv
// Combinational select of one 2-bit square out of a packed 162-bit board.
module sq_mux
    import go_board_pkg::*;
(
    input  logic [BOARD_W-1:0] board_i,
    input  logic [IDX_W-1:0]   idx_i,
    output logic [SQ_BITS-1:0] sq_o
);

    // Index compare per square; out-of-range indices read as empty.
    always_comb begin
        sq_o = '0;
        for (int i = 0; i < NUM_SQ; i++) begin
            if (idx_i == 7'(i)) sq_o = board_i[2*i +: 2];
        end
    end

endmodule

// File: rtl/board_diff_fsm.sv
// Board diff engine: snapshots each completed receiver frame, rejects frames
// with illegal squares, emits one event per changed square in ascending
// index order, then commits the frame as the reference board.
//
// Event handshake: evt_valid_out rises with stable row/col/old/new fields and
// stays high, fields unchanged, until a cycle where evt_ready_in=1 is sampled
// at the clock edge; that edge completes the transfer. evt_ready_in has no
// effect while evt_valid_out=0.
module board_diff_fsm
    import go_board_pkg::*;
(
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [BOARD_W-1:0] board_in,
    input  logic               board_rdy_in,
    output logic               evt_valid_out,
    input  logic               evt_ready_in,
    output logic [3:0]         evt_row_out,
    output logic [3:0]         evt_col_out,
    output logic [1:0]         evt_old_out,
    output logic [1:0]         evt_new_out,
    output logic [BOARD_W-1:0] board_out,
    output logic [6:0]         change_cnt_out,
    output logic               scan_done_out,
    output logic               bad_frame_out,
    output logic               overrun_out,
    output logic               busy_out,
    output logic [4:0]         state_dbg_out
);

    state_t             state_q, state_d;
    logic               rdy_q;
    logic [BOARD_W-1:0] snap_q;
    logic [BOARD_W-1:0] board_q;
    logic [IDX_W-1:0]   idx_q;
    logic [6:0]         cnt_q;
    logic [6:0]         change_cnt_q;
    logic [3:0]         evt_row_q, evt_col_q;
    logic [1:0]         evt_old_q, evt_new_q;
    logic               scan_done_q, bad_frame_q, overrun_q;

    logic [SQ_BITS-1:0] snap_sq, ref_sq;
    logic               frame_evt;
    logic               sq_differs;
    logic               at_last;
    logic               snap_bad;
    rowcol_t            cur_rc;

    assign frame_evt  = ~rdy_q & board_rdy_in;
    assign sq_differs = (snap_sq != ref_sq);
    assign at_last    = (idx_q == LAST_IDX);
    assign snap_bad   = has_illegal(snap_q);
    assign cur_rc     = sq_rowcol(idx_q);

    sq_mux u_snap_mux (
        .board_i (snap_q),
        .idx_i   (idx_q),
        .sq_o    (snap_sq)
    );

    sq_mux u_ref_mux (
        .board_i (board_q),
        .idx_i   (idx_q),
        .sq_o    (ref_sq)
    );

    // State register.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (frame_evt) state_d = S_CHECK;
            S_CHECK: state_d = snap_bad ? S_IDLE : S_SCAN;
            S_SCAN: begin
                if (sq_differs)   state_d = S_EMIT;
                else if (at_last) state_d = S_DONE;
            end
            S_EMIT:  if (evt_ready_in) state_d = at_last ? S_DONE : S_SCAN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State-derived outputs.
    always_comb begin
        evt_valid_out = (state_q == S_EMIT);
        busy_out      = (state_q != S_IDLE);
        state_dbg_out = state_q;
    end

    // Datapath: edge detect, snapshot, scan index, event fields, commit.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            rdy_q        <= 1'b1;
            snap_q       <= '0;
            board_q      <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            change_cnt_q <= '0;
            evt_row_q    <= '0;
            evt_col_q    <= '0;
            evt_old_q    <= '0;
            evt_new_q    <= '0;
            scan_done_q  <= 1'b0;
            bad_frame_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rdy_q       <= board_rdy_in;
            scan_done_q <= 1'b0;
            bad_frame_q <= 1'b0;
            overrun_q   <= frame_evt && (state_q != S_IDLE);
            case (state_q)
                S_IDLE: begin
                    if (frame_evt) begin
                        snap_q <= board_in;
                        idx_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                S_CHECK: bad_frame_q <= snap_bad;
                S_SCAN: begin
                    if (sq_differs) begin
                        evt_row_q <= cur_rc.row;
                        evt_col_q <= cur_rc.col;
                        evt_old_q <= ref_sq;
                        evt_new_q <= snap_sq;
                    end else if (!at_last) begin
                        idx_q <= idx_q + 7'd1;
                    end
                end
                S_EMIT: begin
                    if (evt_ready_in) begin
                        cnt_q <= cnt_q + 7'd1;
                        if (!at_last) idx_q <= idx_q + 7'd1;
                    end
                end
                S_DONE: begin
                    board_q      <= snap_q;
                    change_cnt_q <= cnt_q;
                    scan_done_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign evt_row_out    = evt_row_q;
    assign evt_col_out    = evt_col_q;
    assign evt_old_out    = evt_old_q;
    assign evt_new_out    = evt_new_q;
    assign board_out      = board_q;
    assign change_cnt_out = change_cnt_q;
    assign scan_done_out  = scan_done_q;
    assign bad_frame_out  = bad_frame_q;
    assign overrun_out    = overrun_q;

endmodule

// File: tb/tb_board_diff_fsm.sv
// Bench for board_diff_fsm: directed vector table, random frames against a
// square-array reference model, and hand sequences for overrun and reset.
module tb_board_diff_fsm;

    logic         clk_in = 1'b0;
    logic         rst_n_in;
    logic [161:0] board_in;
    logic         board_rdy_in;
    logic         evt_valid_out;
    logic         evt_ready_in;
    logic [3:0]   evt_row_out, evt_col_out;
    logic [1:0]   evt_old_out, evt_new_out;
    logic [161:0] board_out;
    logic [6:0]   change_cnt_out;
    logic         scan_done_out, bad_frame_out, overrun_out, busy_out;
    logic [4:0]   state_dbg;

    int checks = 0;
    int errors = 0;

    // Reference model: committed board as an array of squares.
    logic [1:0]  ref_b [81];
    int          ref_cnt;
    logic [11:0] exp_q [$];

    typedef struct {
        logic [161:0] board;
        int           stall;
        int           lat;
        int           exp_cnt;
        bit           exp_bad;
    } vec_t;

    vec_t vecs [4];

    always #5 clk_in = ~clk_in;

    board_diff_fsm dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .board_in       (board_in),
        .board_rdy_in   (board_rdy_in),
        .evt_valid_out  (evt_valid_out),
        .evt_ready_in   (evt_ready_in),
        .evt_row_out    (evt_row_out),
        .evt_col_out    (evt_col_out),
        .evt_old_out    (evt_old_out),
        .evt_new_out    (evt_new_out),
        .board_out      (board_out),
        .change_cnt_out (change_cnt_out),
        .scan_done_out  (scan_done_out),
        .bad_frame_out  (bad_frame_out),
        .overrun_out    (overrun_out),
        .busy_out       (busy_out),
        .state_dbg_out  (state_dbg)
    );

    task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [161:0] ref_word();
        logic [161:0] w;
        w = '0;
        for (int i = 0; i < 81; i++) w[2*i +: 2] = ref_b[i];
        return w;
    endfunction

    function automatic bit ref_illegal(input logic [161:0] b);
        bit r;
        r = 0;
        for (int i = 0; i < 81; i++) if (b[2*i +: 2] == 2'b11) r = 1;
        return r;
    endfunction

    task automatic build_exp(input logic [161:0] b);
        logic [3:0] r, c;
        exp_q.delete();
        for (int i = 0; i < 81; i++) begin
            if (b[2*i +: 2] != ref_b[i]) begin
                r = 4'(i / 9);
                c = 4'(i % 9);
                exp_q.push_back({r, c, ref_b[i], b[2*i +: 2]});
            end
        end
    endtask

    task automatic reset_model();
        for (int i = 0; i < 81; i++) ref_b[i] = 2'b00;
        ref_cnt = 0;
    endtask

    // Sends one frame, consumes its events with the given stall, checks
    // fields, order, latency and the committed state afterwards.
    task automatic run_frame(input logic [161:0] b, input int stall, input int lat_in,
                             output bit bad_seen, output int n_acc);
        bit          bad_exp;
        int          n_exp, c, done_at, bad_at, hold, lat;
        bit          holding;
        logic [11:0] held, cur, e;
        bad_exp = ref_illegal(b);
        if (bad_exp) exp_q.delete();
        else build_exp(b);
        n_exp   = exp_q.size();
        lat     = (lat_in >= 0) ? lat_in : 83 + n_exp * (1 + stall);
        done_at = -1;
        bad_at  = -1;
        n_acc   = 0;
        holding = 0;
        hold    = 0;
        held    = '0;
        @(negedge clk_in);
        board_in     = b;
        board_rdy_in = 1'b0;
        @(negedge clk_in);
        board_rdy_in = 1'b1;
        @(posedge clk_in);
        c = 0;
        while (c < 3000 && done_at < 0 && bad_at < 0) begin
            @(negedge clk_in);
            if (evt_ready_in) begin
                evt_ready_in = 1'b0;
                n_acc++;
                holding = 0;
            end
            cur = {evt_row_out, evt_col_out, evt_old_out, evt_new_out};
            if (evt_valid_out) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_event act=%0h exp=none", cur);
                    end else begin
                        e = exp_q.pop_front();
                        chk("event_fields", 162'(cur), 162'(e));
                    end
                    held    = cur;
                    holding = 1;
                    hold    = 0;
                end else begin
                    chk("event_stable", 162'(cur), 162'(held));
                end
                if (hold >= stall) evt_ready_in = 1'b1;
                else hold++;
            end
            if (scan_done_out) done_at = c;
            if (bad_frame_out) bad_at = c;
            c++;
        end
        bad_seen = (bad_at >= 0);
        if (bad_exp) begin
            chk("bad_frame_at", 162'(bad_at), 162'(1));
            chk("events_on_bad", 162'(n_acc), 162'(0));
        end else begin
            chk("scan_done_at", 162'(done_at), 162'(lat));
            chk("events_accepted", 162'(n_acc), 162'(n_exp));
            chk("events_left", 162'(exp_q.size()), 162'(0));
            for (int i = 0; i < 81; i++) ref_b[i] = b[2*i +: 2];
            ref_cnt = n_exp;
        end
        chk("change_cnt", 162'(change_cnt_out), 162'(ref_cnt));
        chk("board_out", board_out, ref_word());
        @(negedge clk_in);
        chk("idle_after", 162'(busy_out), 162'(0));
    endtask

    initial begin
        bit           bad_seen;
        int           n_acc, cyc, stall;
        logic [161:0] b;

        vecs[0] = '{board: (162'(1) << 80), stall: 0, lat: 84, exp_cnt: 1, exp_bad: 0};
        vecs[1] = '{board: (162'(1) << 80), stall: 0, lat: 83, exp_cnt: 0, exp_bad: 0};
        vecs[2] = '{board: (162'(1) << 80) | 162'(3), stall: 0, lat: -1, exp_cnt: 0, exp_bad: 1};
        vecs[3] = '{board: 162'(1) | (162'(2) << 80) | (162'(2) << 160),
                    stall: 5, lat: 101, exp_cnt: 3, exp_bad: 0};

        // Reset with the receiver idling high: no frame edge may be seen.
        rst_n_in     = 1'b0;
        board_in     = '0;
        board_rdy_in = 1'b1;
        evt_ready_in = 1'b0;
        reset_model();
        repeat (3) @(negedge clk_in);
        chk("rst_board_out", board_out, '0);
        chk("rst_busy", 162'(busy_out), 162'(0));
        chk("rst_valid", 162'(evt_valid_out), 162'(0));
        chk("rst_cnt", 162'(change_cnt_out), 162'(0));
        chk("rst_pulses", 162'({scan_done_out, bad_frame_out, overrun_out}), 162'(0));
        chk("rst_state_onehot", 162'($onehot(state_dbg)), 162'(1));
        rst_n_in = 1'b1;
        repeat (6) begin
            @(negedge clk_in);
            chk("post_rst_busy", 162'({busy_out, evt_valid_out}), 162'(0));
        end

        // Directed vectors.
        for (int v = 0; v < 4; v++) begin
            run_frame(vecs[v].board, vecs[v].stall, vecs[v].lat, bad_seen, n_acc);
            chk("tbl_bad", 162'(bad_seen), 162'(vecs[v].exp_bad));
            chk("tbl_change_cnt", 162'(change_cnt_out), 162'(vecs[v].exp_cnt));
        end
        chk("tbl_board_sq40", 162'(board_out[81:80]), 162'(2));

        // Random frames derived from the committed board.
        for (int n = 0; n < 12; n++) begin
            b = ref_word();
            for (int i = 0; i < 81; i++)
                if ($urandom_range(0, 9) == 0) b[2*i +: 2] = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) begin
                cyc = $urandom_range(0, 80);
                b[2*cyc +: 2] = 2'b11;
            end
            stall = $urandom_range(0, 2);
            run_frame(b, stall, -1, bad_seen, n_acc);
        end

        // Overrun during EMIT, then reset while the event is pending.
        b = ref_word();
        b[1:0] = (ref_b[0] == 2'b01) ? 2'b10 : 2'b01;
        @(negedge clk_in);
        board_in     = b;
        board_rdy_in = 1'b0;
        @(negedge clk_in);
        board_rdy_in = 1'b1;
        cyc = 0;
        do begin
            @(negedge clk_in);
            cyc++;
        end while (!evt_valid_out && cyc < 20);
        chk("ovr_valid_seen", 162'(evt_valid_out), 162'(1));
        chk("ovr_first_event_at", 162'(cyc), 162'(3));
        board_rdy_in = 1'b0;
        @(negedge clk_in);
        board_rdy_in = 1'b1;
        @(negedge clk_in);
        chk("ovr_pulse", 162'(overrun_out), 162'(1));
        chk("ovr_valid_held", 162'(evt_valid_out), 162'(1));
        chk("ovr_fields", 162'({evt_row_out, evt_col_out, evt_new_out}), 162'({4'd0, 4'd0, b[1:0]}));
        @(negedge clk_in);
        chk("ovr_pulse_end", 162'(overrun_out), 162'(0));
        rst_n_in = 1'b0;
        @(negedge clk_in);
        chk("midrst_valid", 162'(evt_valid_out), 162'(0));
        chk("midrst_busy", 162'(busy_out), 162'(0));
        chk("midrst_board", board_out, '0);
        rst_n_in = 1'b1;
        reset_model();
        @(negedge clk_in);
        chk("midrst_stay_idle", 162'(busy_out), 162'(0));

        // One more frame from the cleared board.
        b = '0;
        b[1:0]     = 2'b10;
        b[161:160] = 2'b01;
        run_frame(b, 1, -1, bad_seen, n_acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
